// File: rtl/spi_bridge.sv
// -----------------------------------------------------------------------------
// spi_bridge
//   SPI slave front end: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//   The SPI pins are oversampled in the clk domain. Each received byte is
//   presented on data_in with a one-cycle byte_sync strobe. data_out is
//   shifted back out on miso.
//
//   Optional feature macro: SPI_BRIDGE_FRAME_ERR_EN
//     defined   -> frame_err port pulses when a frame ends mid-byte
//     undefined -> no frame_err port; partial bytes are dropped silently
//
// Parameters
//   SYNC_STAGES  synchronizer depth on sclk/cs_n/mosi (2..3)
//
// Ports
//   clk        in   peripheral clock, f_clk >= 8*f_sclk
//   rst_n      in   asynchronous active-low reset
//   sclk       in   SPI clock (asynchronous)
//   cs_n       in   SPI chip select, active low (asynchronous)
//   mosi       in   SPI data master->slave
//   miso       out  SPI data slave->master (registered)
//   byte_sync  out  one-cycle strobe: data_in holds a new byte
//   data_in    out  last complete received byte
//   data_out   in   byte to transmit
//   frame_err  out  aborted partial byte (SPI_BRIDGE_FRAME_ERR_EN only)
// -----------------------------------------------------------------------------
module spi_bridge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   output logic       byte_sync,
   output logic [7:0] data_in,
   input  logic [7:0] data_out
`ifdef SPI_BRIDGE_FRAME_ERR_EN
   ,
   output logic       frame_err
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_p0;
   logic [SYNC_STAGES-1:0] cs_sync_p0;
   logic [SYNC_STAGES-1:0] mosi_sync_p0;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;

   logic                   sclk_d_p1;
   logic                   cs_d_p1;
   logic                   sclk_rise_p1;
   logic                   sclk_fall_p1;
   logic                   cs_rise_p1;
   logic                   cs_fall_p1;
   logic                   mosi_p1;

   state_t                 state;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_shift;
   logic [7:0]             tx_shift;

   // ---- stage p0: pin synchronizers ----
   // The cs_n chain resets to 0 so that a cs_n already held low when reset
   // releases never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_p0 <= '0;
         cs_sync_p0   <= '0;
         mosi_sync_p0 <= '0;
      end else begin
         sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk};
         cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs_n};
         mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
      end
   end

   assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
   assign cs_s   = cs_sync_p0[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

   // ---- stage p1: registered edge flags ----
   // mosi is delayed alongside the flags so the sampled bit lines up with
   // the sclk_rise flag that consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_d_p1    <= 1'b0;
         cs_d_p1      <= 1'b0;
         sclk_rise_p1 <= 1'b0;
         sclk_fall_p1 <= 1'b0;
         cs_rise_p1   <= 1'b0;
         cs_fall_p1   <= 1'b0;
         mosi_p1      <= 1'b0;
      end else begin
         sclk_d_p1    <= sclk_s;
         cs_d_p1      <= cs_s;
         sclk_rise_p1 <= sclk_s & ~sclk_d_p1;
         sclk_fall_p1 <= ~sclk_s & sclk_d_p1;
         cs_rise_p1   <= cs_s & ~cs_d_p1;
         cs_fall_p1   <= ~cs_s & cs_d_p1;
         mosi_p1      <= mosi_s;
      end
   end

   // ---- stage p2: frame FSM, shift registers and registered outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'h00;
         tx_shift  <= 8'h00;
         miso      <= 1'b0;
         byte_sync <= 1'b0;
         data_in   <= 8'h00;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         byte_sync <= 1'b0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               miso <= 1'b0;
               // sclk edges coinciding with cs_fall are ignored
               if (cs_fall_p1) begin
                  state    <= ACTIVE;
                  bit_cnt  <= 3'd0;
                  rx_shift <= 8'h00;
                  tx_shift <= data_out;
               end
            end
            ACTIVE: begin
               if (cs_rise_p1) begin
                  // End of frame wins over any simultaneous sclk edge;
                  // a partial byte is dropped.
                  state   <= IDLE;
                  bit_cnt <= 3'd0;
                  miso    <= 1'b0;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
                  frame_err <= (bit_cnt != 3'd0);
`endif
               end else begin
                  if (sclk_rise_p1) begin
                     rx_shift <= {rx_shift[6:0], mosi_p1};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        data_in   <= {rx_shift[6:0], mosi_p1};
                        byte_sync <= 1'b1;
                     end
                  end else if (sclk_fall_p1) begin
                     // bit_cnt==0 on a fall means a byte just completed:
                     // pick up the decoder's next byte.
                     if (bit_cnt == 3'd0)
                        tx_shift <= data_out;
                     else
                        tx_shift <= {tx_shift[6:0], 1'b0};
                  end
                  miso <= tx_shift[7];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bridge.sv
`timescale 1ns/1ps
module tb_spi_bridge;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       miso;
   logic       byte_sync;
   logic [7:0] data_in;
`ifdef SPI_BRIDGE_FRAME_ERR_EN
   logic       frame_err;
`endif

   int         n_checks = 0;
   int         n_fail = 0;
   int         sync_cnt = 0;
   int         fe_cnt = 0;
   logic [7:0] sb_q[$];
   logic [7:0] mon_exp;
   logic [7:0] dout_next = 8'h00;

   always #5 clk = ~clk;

   spi_bridge #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .byte_sync (byte_sync),
      .data_in   (data_in),
      .data_out  (data_out)
`ifdef SPI_BRIDGE_FRAME_ERR_EN
      ,
      .frame_err (frame_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every byte_sync must match the oldest pushed byte.
   always @(negedge clk) begin
      if (rst_n && byte_sync === 1'b1) begin
         sync_cnt++;
         check("sync_expected", (sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            check("data_in", data_in, mon_exp);
         end
      end
   end

`ifdef SPI_BRIDGE_FRAME_ERR_EN
   always @(negedge clk) begin
      if (rst_n && frame_err === 1'b1) fe_cnt++;
   end
`endif

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "timeout");
   end

   // Master side, f_sclk = f_clk/16; mosi set while sclk low, miso
   // captured just before each rising sclk.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         repeat (8) @(negedge clk);
         rx = {rx[6:0], miso};
         sclk = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (i == 0 && byte_sync === 1'b1) data_out = dout_next;
         end
         sclk = 1'b0;
      end
   endtask

   task automatic frame_start();
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame_end();
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   initial begin
      logic [7:0] rx;
      int         s0;
      logic       miso_seen;

      // 1: reset with random pins
      rst_n = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sclk     = 1'($urandom_range(0, 1));
         cs_n     = 1'($urandom_range(0, 1));
         mosi     = 1'($urandom_range(0, 1));
         data_out = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      check("rst_miso", miso, 0);
      check("rst_byte_sync", byte_sync, 0);
      check("rst_data_in", data_in, 8'h00);
      sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; data_out = 8'h00; dout_next = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_miso", miso, 0);
      check("idle_data_in", data_in, 8'h00);
      check("idle_sync_cnt", sync_cnt, 0);

      // 2: receive 85, 3C
      s0 = sync_cnt;
      frame_start();
      sb_q.push_back(8'h85);
      spi_xfer(8'h85, 8, rx);
      check("rx2_miso_b0", rx, 8'h00);
      sb_q.push_back(8'h3C);
      spi_xfer(8'h3C, 8, rx);
      check("rx2_miso_b1", rx, 8'h00);
      frame_end();
      check("rx2_sync_cnt", sync_cnt - s0, 2);
      check("rx2_data_in", data_in, 8'h3C);
      check("rx2_sb_drain", sb_q.size(), 0);

      // 3: transmit A5 then 5A (swapped in after first byte_sync)
      data_out = 8'hA5;
      dout_next = 8'h5A;
      frame_start();
      sb_q.push_back(8'h11);
      spi_xfer(8'h11, 8, rx);
      check("tx_byte0", rx, 8'hA5);
      sb_q.push_back(8'h22);
      spi_xfer(8'h22, 8, rx);
      check("tx_byte1", rx, 8'h5A);
      frame_end();
      check("tx_idle_miso", miso, 0);
      check("tx_data_in", data_in, 8'h22);
      check("tx_sb_drain", sb_q.size(), 0);

      // 4: abort after 5 bits, then a clean FF frame
      s0 = sync_cnt;
      frame_start();
      spi_xfer(8'hB6, 5, rx);
      check("abort_miso_bits", rx, 8'h0B);
      frame_end();
      check("abort_sync_cnt", sync_cnt - s0, 0);
      check("abort_data_in", data_in, 8'h22);
`ifdef SPI_BRIDGE_FRAME_ERR_EN
      check("abort_frame_err", fe_cnt, 1);
`endif
      frame_start();
      sb_q.push_back(8'hFF);
      spi_xfer(8'hFF, 8, rx);
      frame_end();
      check("ff_data_in", data_in, 8'hFF);
      check("ff_sb_drain", sb_q.size(), 0);
`ifdef SPI_BRIDGE_FRAME_ERR_EN
      check("ff_frame_err", fe_cnt, 1);
`endif

      // 5: reset mid-frame with cs_n held low
      frame_start();
      spi_xfer(8'h99, 3, rx);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_data_in", data_in, 8'h00);
      check("midrst_miso", miso, 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      s0 = sync_cnt;
      spi_xfer(8'h42, 8, rx);
      repeat (16) @(negedge clk);
      check("midrst_no_sync", sync_cnt - s0, 0);
      check("midrst_idle_miso", rx, 8'h00);
      check("midrst_hold", data_in, 8'h00);
      cs_n = 1'b1;
      repeat (16) @(negedge clk);
      frame_start();
      sb_q.push_back(8'h42);
      spi_xfer(8'h42, 8, rx);
      frame_end();
      check("rx42_data_in", data_in, 8'h42);
      check("rx42_sb_drain", sb_q.size(), 0);
`ifdef SPI_BRIDGE_FRAME_ERR_EN
      check("rx42_frame_err", fe_cnt, 1);
`endif

      // 6: sclk toggling with cs_n high
      s0 = sync_cnt;
      miso_seen = 1'b0;
      cs_n = 1'b1;
      for (int e = 0; e < 20; e++) begin
         sclk = ~sclk;
         mosi = 1'($urandom_range(0, 1));
         repeat (4) @(negedge clk);
         miso_seen = miso_seen | (miso !== 1'b0);
      end
      sclk = 1'b0;
      repeat (16) @(negedge clk);
      check("noncs_miso", miso_seen, 0);
      check("noncs_sync_cnt", sync_cnt - s0, 0);
      check("noncs_data_in", data_in, 8'h42);
      check("final_sb_drain", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
